mole_scheduler: RTL and testbench
=================================

MOLE_SCHEDULER -- requirements
Module: mole_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_HOLES, default 8, meaning the number of holes; it SHALL be a power of 2 in the range 2..16.
REQ-002 The block SHALL have parameter CLKS_PER_MS, default 50000, meaning clk cycles per millisecond tick.
REQ-003 The block SHALL have parameter SHOW_MS, default 1000, meaning the initial mole visible time in ms.
REQ-004 The block SHALL have parameter GAP_MS, default 250, meaning the blank time between moles in ms.
REQ-005 The block SHALL have parameter MIN_SHOW_MS, default 300, meaning the speedup floor in ms.
REQ-006 The block SHALL have parameter STEP_MS, default 50, meaning the per-hit speedup decrement in ms.
REQ-007 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-008 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-009 The block SHALL have port play_flag, input, 1 bit: the game is in the PLAY phase.
REQ-010 The block SHALL have port hit_valid, input, 1 bit: a one-cycle strobe meaning a player strike occurred.
REQ-011 The block SHALL have port hit_hole, input, $clog2(NUM_HOLES) bits: the struck hole index, qualified by hit_valid.
REQ-012 The block SHALL have port mole_pos, output, $clog2(NUM_HOLES) bits: the current mole hole index.
REQ-013 The block SHALL have port mole_active, output, 1 bit: the mole is visible at mole_pos.
REQ-014 The block SHALL have port hit_pulse, output, 1 bit: a one-cycle pulse on a successful hit.
REQ-015 The block SHALL have port miss_pulse, output, 1 bit: a one-cycle pulse on mole timeout.
REQ-016 The block SHALL have port mole_complete, output, 1 bit: a one-cycle pulse when a mole finishes by hit or miss.
REQ-017 The block SHALL have port score, output, 12 bits: the running score.

Function
REQ-018 The block SHALL generate a ms_tick strobe for 1 cycle every CLKS_PER_MS cycles; the tick counter SHALL run only outside IDLE and SHALL clear on each state entry.
REQ-019 The FSM SHALL have states IDLE, GAP, SHOW and RESULT, with all outputs registered.
REQ-020 In IDLE, play_flag=1 SHALL move the FSM to GAP on the next cycle.
REQ-021 GAP SHALL last GAP_MS ticks, then move to SHOW with mole_pos loaded from the LFSR.
REQ-022 mole_active SHALL be 1 exactly while the FSM is in SHOW.
REQ-023 In SHOW, hit_valid=1 with hit_hole==mole_pos SHALL move the FSM to RESULT and raise hit_pulse in the cycle RESULT is entered.
REQ-024 In SHOW, a hit_valid with the wrong hole SHALL be ignored, with no penalty and no state change.
REQ-025 In SHOW, when the show timer reaches the current show time with no hit, the FSM SHALL move to RESULT and raise miss_pulse.
REQ-026 A matching hit and a timeout in the same cycle SHALL count as a hit.
REQ-027 RESULT SHALL last exactly 1 cycle, with mole_complete=1, then move to GAP.
REQ-028 mole_complete SHALL coincide with hit_pulse or miss_pulse, never both.
REQ-029 Each hit SHALL add 10 to score, saturating at 1000, so score SHALL never exceed 1000.
REQ-030 A miss SHALL leave score unchanged.
REQ-031 Position generation SHALL use a 16-bit maximal LFSR (taps 16,14,13,11) that advances every cycle and is seeded with 16'hACE1.
REQ-032 The candidate position SHALL be the low $clog2(NUM_HOLES) bits of the LFSR.
REQ-033 If the candidate equals the previous mole_pos, it SHALL be incremented by 1, wrapping modulo NUM_HOLES, so consecutive moles never repeat a hole.
REQ-034 play_flag=0 in any state SHALL return the FSM to IDLE next cycle, clear mole_active and pulses, and hold score.
REQ-035 If play_flag=0 arrives during RESULT, the pulses SHALL still complete that cycle.

Reset
REQ-036 reset=1 SHALL force on the next edge: state IDLE, mole_pos 0, mole_active 0, hit_pulse 0, miss_pulse 0, mole_complete 0, score 0, LFSR 16'hACE1, all timers 0, show time SHOW_MS.
REQ-037 reset SHALL take priority over all other inputs in every state, including mid-SHOW.

Configuration
REQ-038 With macro MOLE_SPEEDUP_EN defined, each hit SHALL reduce the show time by STEP_MS, floored at MIN_SHOW_MS, effective from the next SHOW.
REQ-039 Without MOLE_SPEEDUP_EN, the show time SHALL remain SHOW_MS and the speedup logic SHALL be absent.

Verification (CLKS_PER_MS=4, SHOW_MS=3, GAP_MS=2, NUM_HOLES=8)
REQ-040 Timeout scenario: reset, then play_flag=1 with no hits -> mole_active high for 12 cycles, then miss_pulse and mole_complete for 1 cycle, score 0, and a new mole after 8 GAP cycles.
REQ-041 Hit scenario: hit_valid with hit_hole==mole_pos in SHOW cycle 5 -> hit_pulse and mole_complete the next cycle, score goes 0->10, mole_active 0.
REQ-042 Wrong-hole and simultaneous scenario: a wrong hole in SHOW is ignored; a matching hit on the timeout cycle gives hit_pulse=1 and miss_pulse=0.
REQ-043 Saturation and repeat scenario: 101 hits give score 1000 and never 1010; over 200 moles, mole_pos never equals its predecessor.
REQ-044 Abort scenario: play_flag dropped mid-SHOW gives IDLE with mole_active 0 and score held; reset asserted mid-SHOW gives all reset values on the next cycle.
REQ-045 Speedup scenario, with MOLE_SPEEDUP_EN defined and SHOW_MS=3, STEP_MS=1, MIN_SHOW_MS=1: consecutive hits give show durations of 12, 8, 4, 4 cycles.

Source files
------------

// File: rtl/mole_scheduler.sv
// Whack-a-mole scheduler: paces moles through GAP/SHOW/RESULT on a ms tick, picks holes from an LFSR, keeps score.
// Optional macro MOLE_SPEEDUP_EN shortens the show time by STEP_MS per hit, floored at MIN_SHOW_MS.
module mole_scheduler #(
  parameter int NUM_HOLES   = 8,
  parameter int CLKS_PER_MS = 50000,
  parameter int SHOW_MS     = 1000,
  parameter int GAP_MS      = 250,
  parameter int MIN_SHOW_MS = 300,
  parameter int STEP_MS     = 50
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         play_flag,
  input  logic                         hit_valid,
  input  logic [$clog2(NUM_HOLES)-1:0] hit_hole,
  output logic [$clog2(NUM_HOLES)-1:0] mole_pos,
  output logic                         mole_active,
  output logic                         hit_pulse,
  output logic                         miss_pulse,
  output logic                         mole_complete,
  output logic [11:0]                  score
);

  localparam int               POS_W      = $clog2(NUM_HOLES);
  localparam int               CNT_W      = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLKS_PER_MS - 1);
  localparam logic [15:0]      GAP_LAST   = 16'(GAP_MS - 1);
  localparam logic [11:0]      SCORE_MAX  = 12'd1000;
  localparam logic [11:0]      SCORE_STEP = 12'd10;
  localparam logic [15:0]      LFSR_SEED  = 16'hACE1;

  // Reject configurations the timing and position logic cannot honour.
  if (NUM_HOLES < 2 || NUM_HOLES > 16 || (NUM_HOLES & (NUM_HOLES - 1)) != 0 ||
      CLKS_PER_MS < 1 || GAP_MS < 1 || SHOW_MS < 1 || MIN_SHOW_MS < 1 ||
      MIN_SHOW_MS > SHOW_MS || STEP_MS < 0) begin : g_bad_cfg
    $error("mole_scheduler: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GAP    = 2'd1,
    SHOW   = 2'd2,
    RESULT = 2'd3
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] clk_cnt_q;
  logic [15:0]      ms_cnt_q;
  logic [15:0]      lfsr_q;
  logic [15:0]      show_ms;
  logic             ms_tick;
  logic             hit_match;
  logic             show_done;
  logic             gap_done;
  logic             score_hit;
  logic [POS_W-1:0] cand;
  logic [POS_W-1:0] next_pos;

  assign ms_tick   = (state_q != IDLE) && (clk_cnt_q == CNT_LAST);
  assign hit_match = hit_valid && (hit_hole == mole_pos);
  assign show_done = ms_tick && (ms_cnt_q == (show_ms - 16'd1));
  assign gap_done  = ms_tick && (ms_cnt_q == GAP_LAST);
  assign score_hit = (state_q == SHOW) && (state_d == RESULT) && hit_match;

  // A candidate equal to the last hole is bumped by one; the power-of-2 width wraps it.
  assign cand     = lfsr_q[POS_W-1:0];
  assign next_pos = (cand == mole_pos) ? cand + POS_W'(1) : cand;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (play_flag) state_d = GAP;
      GAP:     if (gap_done) state_d = SHOW;
      SHOW:    if (hit_match || show_done) state_d = RESULT;
      RESULT:  state_d = GAP;
      default: state_d = IDLE;
    endcase
    if (!play_flag) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      clk_cnt_q     <= '0;
      ms_cnt_q      <= '0;
      lfsr_q        <= LFSR_SEED;
      mole_pos      <= '0;
      mole_active   <= 1'b0;
      hit_pulse     <= 1'b0;
      miss_pulse    <= 1'b0;
      mole_complete <= 1'b0;
      score         <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      // Timers restart on every state entry so each phase measures from its first cycle.
      if ((state_d != state_q) || (state_q == IDLE)) begin
        clk_cnt_q <= '0;
        ms_cnt_q  <= '0;
      end else begin
        clk_cnt_q <= ms_tick ? '0 : clk_cnt_q + CNT_W'(1);
        if (ms_tick) ms_cnt_q <= ms_cnt_q + 16'd1;
      end
      mole_active   <= (state_d == SHOW);
      mole_complete <= (state_d == RESULT);
      hit_pulse     <= (state_d == RESULT) && hit_match;
      miss_pulse    <= (state_d == RESULT) && !hit_match;
      if ((state_q == GAP) && (state_d == SHOW)) mole_pos <= next_pos;
      if (score_hit) begin
        score <= (score >= (SCORE_MAX - SCORE_STEP)) ? SCORE_MAX : score + SCORE_STEP;
      end
    end
  end

`ifdef MOLE_SPEEDUP_EN
  logic [15:0] show_ms_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      show_ms_q <= 16'(SHOW_MS);
    end else if (score_hit) begin
      if ({1'b0, show_ms_q} >= 17'(MIN_SHOW_MS + STEP_MS)) show_ms_q <= show_ms_q - 16'(STEP_MS);
      else show_ms_q <= 16'(MIN_SHOW_MS);
    end
  end

  assign show_ms = show_ms_q;
`else
  assign show_ms = 16'(SHOW_MS);
`endif

endmodule

// File: tb/tb_mole_scheduler.sv
// Bench for mole_scheduler: random hits/misses/aborts scored against a game-level model with an expected queue.
// Build with MOLE_SPEEDUP_EN defined to also exercise the shrinking show time.
module tb_mole_scheduler;

  localparam int NH   = 8;
  localparam int PW   = 3;
  localparam int CPM  = 4;
  localparam int SHOW = 3;
  localparam int GAP  = 2;
  localparam int MINS = 1;
  localparam int STEP = 1;
  localparam int EW   = 21;

  logic          clk = 1'b0;
  logic          reset;
  logic          play_flag;
  logic          hit_valid;
  logic [PW-1:0] hit_hole;
  logic [PW-1:0] mole_pos;
  logic          mole_active;
  logic          hit_pulse;
  logic          miss_pulse;
  logic          mole_complete;
  logic [11:0]   score;

  int total = 0;
  int bad   = 0;

  // Each entry: {hit, score after the mole, cycles the mole is visible}.
  logic [EW-1:0] exp_q[$];

  int score_m   = 0;
  int show_ms_m = SHOW;
  int hits_m    = 0;

  mole_scheduler #(
    .NUM_HOLES  (NH),
    .CLKS_PER_MS(CPM),
    .SHOW_MS    (SHOW),
    .GAP_MS     (GAP),
    .MIN_SHOW_MS(MINS),
    .STEP_MS    (STEP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .play_flag    (play_flag),
    .hit_valid    (hit_valid),
    .hit_hole     (hit_hole),
    .mole_pos     (mole_pos),
    .mole_active  (mole_active),
    .hit_pulse    (hit_pulse),
    .miss_pulse   (miss_pulse),
    .mole_complete(mole_complete),
    .score        (score)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: run still going at time %0t, required end before it", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_mole_pos"}, mole_pos, 0);
    check({tag, "_mole_active"}, mole_active, 0);
    check({tag, "_hit_pulse"}, hit_pulse, 0);
    check({tag, "_miss_pulse"}, miss_pulse, 0);
    check({tag, "_mole_complete"}, mole_complete, 0);
    check({tag, "_score"}, score, 0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [15:0]   lfsr_m = 16'hACE1;
  logic [15:0]   lfsr_prev;
  logic [PW-1:0] last_pos_m = '0;
  logic [PW-1:0] cand_m;
  logic [EW-1:0] e;
  logic          rst_s;
  logic          pf_s;
  logic          prev_active = 1'b0;
  logic          gap_valid = 1'b0;
  int            show_cnt = 0;
  int            gap_cnt = 0;

  always begin
    @(posedge clk);
    rst_s     = reset;
    pf_s      = play_flag;
    lfsr_prev = lfsr_m;
    lfsr_m    = rst_s ? 16'hACE1 : {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    #1;
    if (rst_s) begin
      last_pos_m  = '0;
      gap_valid   = 1'b0;
      prev_active = 1'b0;
    end else begin
      if (mole_active && !prev_active) begin
        // The hole is drawn from the generator value present before the edge that shows the mole.
        cand_m = lfsr_prev[PW-1:0];
        if (cand_m == last_pos_m) cand_m = cand_m + 3'd1;
        check("mole_pos", mole_pos, cand_m);
        check("no_repeat", mole_pos != last_pos_m, 1);
        if (gap_valid) check("gap_cycles", gap_cnt, GAP * CPM);
        last_pos_m = cand_m;
        show_cnt   = 0;
        gap_valid  = 1'b0;
      end
      if (mole_active) show_cnt++;
      if (mole_complete) begin
        check("exp_q_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("hit_pulse", hit_pulse, e[20]);
          check("miss_pulse", miss_pulse, !e[20]);
          check("score", score, e[19:8]);
          check("score_cap", score <= 1000, 1);
          check("show_cycles", show_cnt, e[7:0]);
          check("result_inactive", mole_active, 0);
        end
        gap_cnt   = 0;
        gap_valid = 1'b1;
      end else begin
        if (hit_pulse || miss_pulse) check("stray_pulse", {hit_pulse, miss_pulse}, 0);
        if (!mole_active && gap_valid) gap_cnt++;
      end
      if (!pf_s) gap_valid = 1'b0;
      prev_active = mole_active;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_show(output bit ok);
    int guard = 0;
    while (mole_active !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    ok = (guard < 100);
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL mole_wait: no mole after %0d cycles, required within 100", guard);
    end
  endtask

  // k_sel: >=0 fixed hit cycle, -1 random hit cycle, -2 hit on the timeout cycle.
  task automatic run_mole(input bit do_hit, input bit do_wrong, input int k_sel);
    bit ok;
    int cyc, k, w;
    wait_show(ok);
    if (!ok) return;
    cyc = show_ms_m * CPM;
    k = (k_sel >= 0) ? k_sel : (k_sel == -2) ? cyc - 1 : int'($urandom_range(0, cyc - 1));
    w = int'($urandom_range(0, cyc - 1));
    if (do_hit && w == k) do_wrong = 1'b0;
    if (do_hit) begin
      score_m = (score_m + 10 > 1000) ? 1000 : score_m + 10;
      hits_m++;
      exp_q.push_back({1'b1, 12'(score_m), 8'(k + 1)});
`ifdef MOLE_SPEEDUP_EN
      show_ms_m = (show_ms_m - STEP < MINS) ? MINS : show_ms_m - STEP;
`endif
    end else begin
      exp_q.push_back({1'b0, 12'(score_m), 8'(cyc)});
    end
    for (int i = 0; i < cyc; i++) begin
      hit_valid = 1'b0;
      if (do_hit && i == k) begin
        hit_valid = 1'b1;
        hit_hole  = mole_pos;
      end else if (do_wrong && i == w) begin
        hit_valid = 1'b1;
        hit_hole  = mole_pos ^ PW'($urandom_range(1, NH - 1));
      end
      @(negedge clk);
      if (do_hit && i == k) break;
    end
    hit_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit ok;
    int r;
    reset     = 1'b1;
    play_flag = 1'b0;
    hit_valid = 1'b0;
    hit_hole  = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("after_reset");

    play_flag = 1'b1;
    run_mole(1'b0, 1'b0, 0);   // timeout with no strikes
    run_mole(1'b1, 1'b0, 5);   // hit in SHOW cycle 5
    run_mole(1'b1, 1'b1, -2);  // wrong hole, then hit on the timeout cycle
    run_mole(1'b0, 1'b1, 0);   // wrong hole only, still a miss
    run_mole(1'b1, 1'b0, -1);
    run_mole(1'b1, 1'b0, -1);

    // Drop play mid-mole: back to idle, score held.
    wait_show(ok);
    repeat (4) @(negedge clk);
    play_flag = 1'b0;
    @(negedge clk);
    check("abort_active", mole_active, 0);
    check("abort_score", score, score_m);
    check("abort_complete", mole_complete, 0);
    repeat (3) @(negedge clk);
    check("abort_stays_idle", mole_active, 0);
    play_flag = 1'b1;

    // Reset mid-mole.
    run_mole(1'b1, 1'b0, -1);
    wait_show(ok);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_values("mid_show_reset");
    reset     = 1'b0;
    score_m   = 0;
    show_ms_m = SHOW;

    // Long random game: enough hits to reach the score ceiling.
    for (int m = 0; m < 220; m++) begin
      r = int'($urandom_range(0, 99));
      if (r < 70)      run_mole(1'b1, r[0], -1);
      else if (r < 85) run_mole(1'b1, 1'b0, -2);
      else if (r < 93) run_mole(1'b0, 1'b0, 0);
      else             run_mole(1'b0, 1'b1, 0);
    end
    repeat (3) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    check("final_score", score, score_m);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
